alu_issue_unit: RTL and testbench

- Upstream control stage for the 16-bit ALU.
- Holds a small register file and accepts one operation request at a time.
- Fetches the two operands, drives them onto the ALU's a/b inputs, and runs the ALU's cs/ready handshake.
- Captures the ALU bus result and writes it back to the destination register, with a completion pulse.

---
 rtl/alu_issue_pkg.sv | 17 +
 rtl/issue_regfile.sv | 41 ++++
 rtl/alu_issue_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and defaults for the ALU issue unit.
package alu_issue_pkg;

  localparam int unsigned AluDw         = 16;
  localparam int unsigned AluAw         = 3;
  localparam int unsigned AluNreg       = 8;
  localparam int unsigned AluTimeoutCyc = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StStart = 3'd2,
    StWait  = 3'd3,
    StWb    = 3'd4
  } issue_state_e;

endpackage

// File: rtl/issue_regfile.sv
// NREG x DW register file: two combinational read ports, two write ports with
// the writeback port taking priority over the external load port.
module issue_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW   = AluDw,
  parameter int unsigned NREG = AluNreg,
  parameter int unsigned AW   = AluAw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o,
  input  logic          wb_en_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          ld_en_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_data_i
);

  logic [DW-1:0] regs_q [NREG];

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (ld_en_i) regs_q[ld_addr_i] <= ld_data_i;
      // Later assignment wins, so writeback overrides a colliding load.
      if (wb_en_i) regs_q[wb_addr_i] <= wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage for the 16-bit ALU: operand fetch, cs/ready handshake, writeback.
// Optional watchdog with sticky err enabled by defining ALU_TIMEOUT_EN.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int unsigned DW          = AluDw,
  parameter int unsigned NREG        = AluNreg,
  parameter int unsigned AW          = AluAw,
  parameter int unsigned TIMEOUT_CYC = AluTimeoutCyc
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [AW-1:0] issue_dst,
  input  logic [AW-1:0] issue_srca,
  input  logic [AW-1:0] issue_srcb,
  input  logic          issue_imm_en,
  input  logic [DW-1:0] issue_imm,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          alu_cs,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_bus,
  input  logic          alu_ready,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          err
);

  issue_state_e  state_q;
  logic [AW-1:0] dst_q, srca_q, srcb_q;
  logic          imm_en_q;
  logic [DW-1:0] imm_q, a_q, b_q, bus_q, result_q;
  logic          cs_q, done_q;
  logic [DW-1:0] rdata_a, rdata_b, opa, opb;
  logic          timeout;

  issue_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr_a_i (srca_q),
    .raddr_b_i (srcb_q),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .wb_en_i   (state_q == StWb),
    .wb_addr_i (dst_q),
    .wb_data_i (bus_q),
    .ld_en_i   (ld_en),
    .ld_addr_i (ld_addr),
    .ld_data_i (ld_data)
  );

  // A load landing on a source register during READ is forwarded.
  assign opa = (ld_en && ld_addr == srca_q) ? ld_data : rdata_a;
  assign opb = imm_en_q                     ? imm_q   :
               (ld_en && ld_addr == srcb_q) ? ld_data : rdata_b;

  assign issue_ready = (state_q == StIdle);
  assign alu_cs      = cs_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign done        = done_q;
  assign result      = result_q;

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign timeout = (state_q == StStart || state_q == StWait) &&
                   (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (timeout) err_q <= 1'b1;
      if ((state_q == StStart || state_q == StWait) && !timeout) begin
        cnt_q <= cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cs_q     <= 1'b0;
      bus_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (timeout) begin
      state_q <= StIdle;
      cs_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (issue_valid) begin
            dst_q    <= issue_dst;
            srca_q   <= issue_srca;
            srcb_q   <= issue_srcb;
            imm_en_q <= issue_imm_en;
            imm_q    <= issue_imm;
            state_q  <= StRead;
          end
        end
        StRead: begin
          a_q     <= opa;
          b_q     <= opb;
          // Raise cs on START entry only if the ALU is idle right now.
          cs_q    <= alu_ready;
          state_q <= StStart;
        end
        StStart: begin
          if (!cs_q) begin
            cs_q <= alu_ready;
          end else if (!alu_ready) begin
            cs_q    <= 1'b0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (alu_ready) begin
            // result and done become visible together during WB.
            bus_q    <= alu_bus;
            result_q <= alu_bus;
            done_q   <= 1'b1;
            state_q  <= StWb;
          end
        end
        StWb: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed self-checking bench for alu_issue_unit with a small adder ALU stub.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_dst = '0, issue_srca = '0, issue_srcb = '0;
  logic        issue_imm_en = 1'b0;
  logic [15:0] issue_imm = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        alu_cs;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_bus;
  logic        alu_ready;
  logic        done;
  logic [15:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [15:0] res;
  bit          ok;

  always #5 clk = ~clk;

  alu_issue_unit dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_dst    (issue_dst),
    .issue_srca   (issue_srca),
    .issue_srcb   (issue_srcb),
    .issue_imm_en (issue_imm_en),
    .issue_imm    (issue_imm),
    .ld_en        (ld_en),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .alu_cs       (alu_cs),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_bus      (alu_bus),
    .alu_ready    (alu_ready),
    .done         (done),
    .result       (result),
    .err          (err)
  );

  // Adder ALU stub: accepts cs while ready, busy for three cycles, then a+b.
  bit stub_hold_busy = 1'b0;
  bit stub_hang = 1'b0;
  bit stub_busy;
  int stub_cnt;
  always @(posedge clk) begin
    if (rst) begin
      alu_ready <= 1'b1;
      alu_bus   <= '0;
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
    end else if (stub_busy) begin
      if (!stub_hang) begin
        if (stub_cnt == 0) begin
          alu_bus   <= alu_a + alu_b;
          alu_ready <= 1'b1;
          stub_busy <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end else if (stub_hold_busy) begin
      alu_ready <= 1'b0;
    end else if (alu_cs && alu_ready) begin
      stub_busy <= 1'b1;
      alu_ready <= 1'b0;
      stub_cnt  <= 2;
    end else begin
      alu_ready <= 1'b1;
    end
  end

  task automatic load_reg(input logic [2:0] addr, input logic [15:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Presents a request for one cycle; returns at the negedge of cycle T+1.
  task automatic drive_issue(input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb,
                             input logic imm_en, input logic [15:0] imm);
    issue_valid = 1'b1; issue_dst = dst; issue_srca = sa; issue_srcb = sb;
    issue_imm_en = imm_en; issue_imm = imm;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] dst, input logic [2:0] sa, input logic [2:0] sb,
                        input logic imm_en, input logic [15:0] imm,
                        output logic [15:0] r, output bit seen);
    drive_issue(dst, sa, sb, imm_en, imm);
    wait_done(60, seen);
    r = result;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", issue_ready); end
    checks++;
    if (alu_cs !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", alu_cs); end
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_done_err: got %b%b want 00", done, err);
    end
    checks++;
    if (result !== 16'h0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin
      errors++; $display("FAIL rst_data: got %h %h %h want 0 0 0", result, alu_a, alu_b);
    end
    checks++;
  endtask

  task automatic test_add();
    load_reg(3'd1, 16'h0003);
    load_reg(3'd2, 16'h0005);
    drive_issue(3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    if (alu_cs !== 1'b0 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL add_t1: got cs=%b ready=%b want 0 0", alu_cs, issue_ready);
    end
    checks++;
    @(negedge clk);
    if (alu_cs !== 1'b1) begin errors++; $display("FAIL add_cs_t2: got %b want 1", alu_cs); end
    checks++;
    wait_done(60, ok);
    if (!ok || result !== 16'h0008) begin
      errors++; $display("FAIL add_result: got done=%b %h want 1 0008", ok, result);
    end
    checks++;
    @(negedge clk);
    if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", done); end
    checks++;
    run_op(3'd4, 3'd3, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h0008) begin
      errors++; $display("FAIL add_r3: got %h want 0008", res);
    end
    checks++;
  endtask

  task automatic test_imm_wrap();
    load_reg(3'd1, 16'h0001);
    load_reg(3'd5, 16'h7777);
    drive_issue(3'd5, 3'd1, 3'd2, 1'b1, 16'hFFFF);
    @(negedge clk);
    if (alu_a !== 16'h0001 || alu_b !== 16'hFFFF) begin
      errors++; $display("FAIL imm_operands: got %h %h want 0001 ffff", alu_a, alu_b);
    end
    checks++;
    wait_done(60, ok);
    if (!ok || result !== 16'h0000) begin
      errors++; $display("FAIL imm_wrap: got done=%b %h want 1 0000", ok, result);
    end
    checks++;
    @(negedge clk);
    run_op(3'd4, 3'd5, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h0000) begin errors++; $display("FAIL imm_r5: got %h want 0000", res); end
    checks++;
  endtask

  task automatic test_stall();
    int bad = 0;
    stub_hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    drive_issue(3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      if (alu_cs !== 1'b0) bad++;
      @(negedge clk);
    end
    if (bad != 0) begin errors++; $display("FAIL stall_cs: got %0d high cycles want 0", bad); end
    checks++;
    stub_hold_busy = 1'b0;
    wait_done(60, ok);
    if (!ok || result !== 16'h0006) begin
      errors++; $display("FAIL stall_result: got done=%b %h want 1 0006", ok, result);
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int bad = 0;
    int extra = 0;
    issue_valid = 1'b1; issue_dst = 3'd7; issue_srca = 3'd2; issue_srcb = 3'd2;
    issue_imm_en = 1'b0;
    @(negedge clk);
    issue_dst = 3'd1; issue_srca = 3'd1;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (issue_ready !== 1'b0) bad++;
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    issue_valid = 1'b0;
    if (bad != 0) begin errors++; $display("FAIL busy_ready: got %0d ready cycles want 0", bad); end
    checks++;
    if (!ok || result !== 16'h000A) begin
      errors++; $display("FAIL busy_result: got done=%b %h want 1 000a", ok, result);
    end
    checks++;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    if (extra != 0) begin errors++; $display("FAIL busy_second_op: got %0d dones want 0", extra); end
    checks++;
    run_op(3'd0, 3'd1, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h0001) begin errors++; $display("FAIL busy_r1: got %h want 0001", res); end
    checks++;
  endtask

  task automatic test_ld_collision();
    load_reg(3'd1, 16'h0003);
    drive_issue(3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    wait_done(60, ok);
    ld_en = 1'b1; ld_addr = 3'd3; ld_data = 16'h1234;
    @(negedge clk);
    ld_en = 1'b0;
    run_op(3'd4, 3'd3, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h0008) begin errors++; $display("FAIL wb_wins: got %h want 0008", res); end
    checks++;
  endtask

  task automatic test_forward();
    drive_issue(3'd2, 3'd4, 3'd0, 1'b1, 16'h0);
    ld_en = 1'b1; ld_addr = 3'd4; ld_data = 16'h00AA;
    @(negedge clk);
    ld_en = 1'b0;
    if (alu_a !== 16'h00AA) begin errors++; $display("FAIL fwd_alu_a: got %h want 00aa", alu_a); end
    checks++;
    wait_done(60, ok);
    if (!ok || result !== 16'h00AA) begin
      errors++; $display("FAIL fwd_result: got done=%b %h want 1 00aa", ok, result);
    end
    checks++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int hang_cycles;
`ifdef ALU_TIMEOUT_EN
    hang_cycles = 8;
`else
    hang_cycles = 100;
`endif
    stub_hang = 1'b1;
    drive_issue(3'd6, 3'd1, 3'd2, 1'b0, 16'h0);
    ok = 1'b0;
    for (int i = 0; i < hang_cycles; i++) begin
      if (done) ok = 1'b1;
      @(negedge clk);
    end
    if (ok || issue_ready !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL hang_wait: got done=%b ready=%b err=%b want 0 0 0", ok, issue_ready, err);
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    if (issue_ready !== 1'b1 || alu_cs !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl: got ready=%b cs=%b done=%b err=%b want 1000",
                         issue_ready, alu_cs, done, err);
    end
    checks++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || result !== 16'h0) begin
      errors++; $display("FAIL midrst_data: got %h %h %h want 0 0 0", alu_a, alu_b, result);
    end
    checks++;
    rst = 1'b0;
    stub_hang = 1'b0;
    @(negedge clk);
    run_op(3'd4, 3'd1, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h0000) begin errors++; $display("FAIL midrst_regs: got %h want 0000", res); end
    checks++;
  endtask

`ifdef ALU_TIMEOUT_EN
  task automatic test_timeout();
    int dones = 0;
    load_reg(3'd3, 16'h5555);
    stub_hang = 1'b1;
    drive_issue(3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    if (err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", err); end
    checks++;
    @(negedge clk);
    if (err !== 1'b1 || issue_ready !== 1'b1 || dones != 0) begin
      errors++; $display("FAIL to_abort: got err=%b ready=%b dones=%0d want 1 1 0",
                         err, issue_ready, dones);
    end
    checks++;
    stub_hang = 1'b0;
    repeat (5) @(negedge clk);
    run_op(3'd4, 3'd3, 3'd0, 1'b1, 16'h0, res, ok);
    if (!ok || res !== 16'h5555 || err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %h err=%b want 5555 1", res, err);
    end
    checks++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (err !== 1'b0) begin errors++; $display("FAIL to_rst_clear: got %b want 0", err); end
    checks++;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_imm_wrap();
    test_stall();
    test_busy_ignore();
    test_ld_collision();
    test_forward();
`ifdef ALU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
